// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: types and constants shared by main_memory and the cache.
//   mem_state_t     : control FSM states of main_memory
//   BLOCK_WORDS     : words per burst block (16 bytes)
//   DEFAULT_LATENCY : acceptance-to-first-beat latency in cycles
//   word_t          : four byte lanes; lane i is the byte at word address + i
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } mem_state_t;

  localparam int BLOCK_WORDS       = 4;
  localparam int DEFAULT_LATENCY   = 4;
  localparam int DEFAULT_MEM_BYTES = 8192;

  typedef logic [3:0][7:0] word_t;

  // Byte read formatting: selected lane moved to lane 0, upper lanes zero.
  function automatic word_t byte_to_lane0(input word_t w, input logic [1:0] sel);
    word_t r;
    r    = '0;
    r[0] = w[sel];
    return r;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: byte-addressed storage organised as 4-byte words.
//   clk     : clock, write on rising edge
//   wr_en   : write strobe
//   wr_be   : per-byte-lane write enable
//   wr_addr : word address of the write
//   wr_data : write data, lane i -> byte i of the word
//   rd_addr : word address of the combinational read port
//   rd_data : word at rd_addr
// Contents have no reset; they survive rst_b of the controller.
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int WORDS = 2048,
  parameter int WAW   = 11
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [3:0]     wr_be,
  input  logic [WAW-1:0] wr_addr,
  input  word_t          wr_data,
  input  logic [WAW-1:0] rd_addr,
  output word_t          rd_data
);

  word_t mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][i] <= wr_data[i];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/main_memory.sv
// main_memory: fixed-latency main memory with word, byte and 4-word burst access.
//   clk, rst_b      : clock; asynchronous active-low reset
//   req_valid/ready : request handshake, ready only in IDLE
//   req_write       : 1 = write, 0 = read
//   req_byte_mode   : single-byte access
//   req_burst       : read the aligned 16-byte block, critical word first
//   req_addr        : byte address, wraps modulo MEM_BYTES
//   req_wdata       : write data, lane i = byte at word address + i
//   rsp_valid       : one cycle per response beat
//   rsp_data        : read data or post-write readback, held between responses
//   rsp_last        : final beat of a response
//   busy            : controller not IDLE
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency count running; also holds the single beat of a non-burst reply
// BURST | beats 0..3 of a burst read on consecutive cycles
//
// Writes commit on the acceptance edge (only possible in IDLE) and reads are
// only sampled in WAIT/BURST, so storage is never read and written in the
// same cycle; write readback therefore always sees the new data.
module main_memory
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte_mode,
  input  logic        req_burst,
  input  logic [31:0] req_addr,
  input  word_t       req_wdata,
  output logic        rsp_valid,
  output word_t       rsp_data,
  output logic        rsp_last,
  output logic        busy
);

  localparam int AW  = $clog2(MEM_BYTES);
  localparam int WAW = AW - 2;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  mem_state_t      state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      beat, beat_nx;
  logic            rsp_valid_nx, rsp_last_nx;

  logic [AW-1:0]   cap_addr;
  logic            cap_write, cap_byte, cap_burst;

  logic            accept;
  logic            wr_en;
  logic [3:0]      wr_be;
  word_t           wr_data;
  logic [1:0]      word_idx;
  logic [WAW-1:0]  rd_addr;
  word_t           rd_word;
  word_t           beat_word;

  // Address bits above the storage size are ignored (address wrap).
  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Write port fed straight from the request so it commits on acceptance.
  assign wr_en   = accept && req_write;
  assign wr_be   = req_byte_mode ? (4'b0001 << req_addr[1:0]) : 4'b1111;
  assign wr_data = req_byte_mode ? word_t'({4{req_wdata[0]}}) : req_wdata;

  // Burst beats walk the aligned block starting at the requested word.
  assign word_idx = cap_addr[3:2] + beat;
  assign rd_addr  = cap_burst ? {cap_addr[AW-1:4], word_idx} : cap_addr[AW-1:2];

  // Byte reads are lane-0 formatted; write readback returns the whole word.
  assign beat_word = (cap_byte && !cap_write && !cap_burst)
                   ? byte_to_lane0(rd_word, cap_addr[1:0])
                   : rd_word;

  mem_array #(
    .WORDS (MEM_BYTES / 4),
    .WAW   (WAW)
  ) u_mem_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_addr (req_addr[AW-1:2]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    beat_nx      = beat;
    rsp_valid_nx = 1'b0;
    rsp_last_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = '0;
          beat_nx  = '0;
        end
      end
      WAIT: begin
        if (rsp_last) begin
          // Single beat was on the bus this cycle.
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          rsp_valid_nx = 1'b1;
          rsp_last_nx  = !cap_burst;
          if (cap_burst) begin
            state_nx = BURST;
            beat_nx  = 2'd1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      BURST: begin
        if (rsp_last) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          beat_nx  = '0;
        end else begin
          rsp_valid_nx = 1'b1;
          rsp_last_nx  = (beat == 2'(BLOCK_WORDS - 1));
          beat_nx      = beat + 2'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        beat_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      beat      <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_byte  <= 1'b0;
      cap_burst <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      beat      <= beat_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_last  <= rsp_last_nx;
      if (rsp_valid_nx) rsp_data <= beat_word;
      if (accept) begin
        cap_addr  <= req_addr[AW-1:0];
        cap_write <= req_write;
        cap_byte  <= req_byte_mode;
        cap_burst <= req_burst && !req_write;
      end
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed and random checks of main_memory against a
// byte-array reference model.
module tb_main_memory;
  import mips_mem_pkg::*;

  localparam int MEM_BYTES = 8192;
  localparam int LAT       = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte_mode = 1'b0;
  logic        req_burst = 1'b0;
  logic [31:0] req_addr = '0;
  word_t       req_wdata = '0;
  logic        rsp_valid;
  word_t       rsp_data;
  logic        rsp_last;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] ref_mem [MEM_BYTES];

  main_memory #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_byte_mode (req_byte_mode),
    .req_burst     (req_burst),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t ref_word(input int a);
    int al;
    al = a & (MEM_BYTES - 1) & ~3;
    return {ref_mem[al+3], ref_mem[al+2], ref_mem[al+1], ref_mem[al]};
  endfunction

  // Issue one request, update the model, and check every beat of the reply.
  task automatic do_req(input bit wr, input bit bt, input bit bu, input logic [31:0] addr,
                        input word_t wd, output logic [3:0][31:0] beats);
    word_t exp_b [4];
    int a, acc, waited, nb;
    beats = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_byte_mode = bt; req_burst = bu;
    req_addr = addr; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("req_accept_wait", 128'(waited < 50), 128'(1));
    if (waited >= 50) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    check_eq("busy_after_accept", {busy, req_ready}, 2'b10);
    a = int'(addr & 32'(MEM_BYTES - 1));
    if (wr) begin
      if (bt) ref_mem[a] = wd[0];
      else for (int i = 0; i < 4; i++) ref_mem[(a & ~3) + i] = wd[i];
    end
    nb = (bu && !wr) ? 4 : 1;
    for (int k = 0; k < nb; k++) begin
      if (bu && !wr) exp_b[k] = ref_word((a & ~15) | ((((a >> 2) + k) & 3) << 2));
      else if (bt && !wr) exp_b[k] = {24'h0, ref_mem[a]};
      else exp_b[k] = ref_word(a);
    end
    for (int k = 0; k < nb; k++) begin
      if (k == 0) begin
        waited = 0;
        while (!rsp_valid && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        check_eq("beat0_latency", 128'(cyc - acc), 128'(LAT));
      end else begin
        @(negedge clk);
      end
      check_eq("beat_valid", 128'(rsp_valid), 128'(1));
      check_eq("beat_data", 128'(rsp_data), 128'(exp_b[k]));
      check_eq("beat_last", 128'(rsp_last), 128'(k == nb - 1));
      beats[k] = rsp_data;
    end
    @(negedge clk);
    check_eq("valid_after_last", 128'(rsp_valid), 128'(0));
  endtask

  logic [3:0][31:0] bts;
  int a1, a2, lastc, extra, waited;
  logic [31:0] ra;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {rsp_valid, rsp_last, busy, rsp_data}, 35'h0);
    rst_b = 1'b1;
    #1;
    check_eq("ready_after_reset", 128'(req_ready), 128'(1));

    // Preload the working region 0x000..0x3FF with random words.
    for (int w = 0; w < 256; w++) do_req(1, 0, 0, 32'(w * 4), word_t'($urandom), bts);

    // Word write then read with offset.
    do_req(1, 0, 0, 32'h100, 32'h44332211, bts);
    check_eq("word_write_readback", 128'(bts[0]), 128'(32'h44332211));
    do_req(0, 0, 0, 32'h102, 32'h0, bts);
    check_eq("word_read_0x102", 128'(bts[0]), 128'(32'h44332211));

    // Byte write then word and byte reads.
    do_req(1, 1, 0, 32'h101, 32'h000000AB, bts);
    do_req(0, 0, 0, 32'h100, 32'h0, bts);
    check_eq("byte_write_word_read", 128'(bts[0]), 128'(32'h4433AB11));
    do_req(0, 1, 0, 32'h101, 32'h0, bts);
    check_eq("byte_read_0x101", 128'(bts[0]), 128'(32'h000000AB));

    // Burst, critical word first.
    do_req(1, 0, 0, 32'h200, 32'hA0A0A0A0, bts);
    do_req(1, 0, 0, 32'h204, 32'hA1A1A1A1, bts);
    do_req(1, 0, 0, 32'h208, 32'hA2A2A2A2, bts);
    do_req(1, 0, 0, 32'h20C, 32'hA3A3A3A3, bts);
    do_req(0, 0, 1, 32'h208, 32'h0, bts);
    check_eq("burst_order", 128'(bts), 128'({32'hA1A1A1A1, 32'hA0A0A0A0, 32'hA3A3A3A3, 32'hA2A2A2A2}));

    // Back-to-back with req_valid held high throughout.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte_mode = 1'b0; req_burst = 1'b0;
    req_addr = 32'h100;
    @(negedge clk);
    a1 = cyc;
    req_addr = 32'h204;
    a2 = -1; lastc = -1;
    for (int n = 0; n < 30 && a2 < 0; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lastc = cyc;
        check_eq("b2b_first_data", 128'(rsp_data), 128'(ref_word(32'h100)));
      end
      if (req_ready) begin
        @(negedge clk);
        a2 = cyc;
        req_valid = 1'b0;
      end
    end
    check_eq("b2b_accept_gap", 128'(a2 - a1), 128'(LAT + 2));
    check_eq("b2b_after_last", 128'(a2 - lastc), 128'(2));
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("b2b_second_latency", 128'(cyc - a2), 128'(LAT));
    check_eq("b2b_second_data", {rsp_valid, rsp_last, rsp_data}, {2'b11, ref_word(32'h204)});

    // Request pulsed while busy is dropped.
    fork
      do_req(0, 0, 0, 32'h110, 32'h0, bts);
      begin
        repeat (3) @(negedge clk);
        check_eq("ready_while_busy", 128'(req_ready), 128'(0));
        req_valid = 1'b1; req_write = 1'b1; req_byte_mode = 1'b0; req_burst = 1'b0;
        req_addr = 32'h300; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
      end
    join
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check_eq("busy_pulse_no_rsp", 128'(extra), 128'(0));
    do_req(0, 0, 0, 32'h300, 32'h0, bts);

    // Reset in the middle of a burst.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte_mode = 1'b0; req_burst = 1'b1;
    req_addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_eq("burst_beat1_present", 128'(rsp_valid), 128'(1));
    rst_b = 1'b0;
    #1;
    check_eq("reset_abort", {rsp_valid, rsp_last, busy, rsp_data}, 35'h0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check_eq("ready_after_reset2", 128'(req_ready), 128'(1));
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check_eq("no_beats_after_reset", 128'(extra), 128'(0));
    do_req(0, 0, 0, 32'h100, 32'h0, bts);
    check_eq("storage_kept", 128'(bts[0]), 128'(32'h4433AB11));

    // Address wrap.
    do_req(1, 0, 0, 32'h2000_0010, 32'h5A5A1234, bts);
    do_req(0, 0, 0, 32'h0000_0010, 32'h0, bts);
    check_eq("wrap_read", 128'(bts[0]), 128'(32'h5A5A1234));

    // Random mix within the preloaded region, with random upper address bits.
    for (int n = 0; n < 80; n++) begin
      ra = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 1023));
      do_req(1'($urandom), 1'($urandom), 1'($urandom), ra, word_t'($urandom), bts);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 The parameters SHALL be, one per line:
- MEM_BYTES, 8192, storage size in bytes (power of two, multiple of 16)
- LATENCY, 4, cycles from request acceptance to first response beat (>=1)
REQ-002 The ports SHALL be, one per line:
- clk  in  1  clock, all state on rising edge
- rst_b  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_byte_mode  in  1  single-byte access
- req_burst  in  1  read the 4-word (16-byte) block containing req_addr; ignored when req_write=1
- req_addr  in  32  byte address
- req_wdata  in  4x8  write data; lane i = byte at word address + i
- rsp_valid  out  1  response beat present, one cycle per beat
- rsp_data  out  4x8  read data or post-write readback
- rsp_last  out  1  final beat of the response
- busy  out  1  not IDLE

Function
REQ-003 The block SHALL implement states IDLE, WAIT and BURST.
REQ-004 On acceptance, the block SHALL capture the address, mode and data, and move IDLE->WAIT with latency counter=0.
REQ-005 In WAIT, the counter SHALL increment each cycle; when counter==LATENCY-1, the next cycle SHALL drive beat 0 with rsp_valid=1.
- Beat 0 therefore occurs exactly LATENCY cycles after the acceptance edge.
REQ-006 For non-burst requests, beat 0 SHALL have rsp_last=1, and the block SHALL return to IDLE on the following edge.
REQ-007 For burst reads, beats 0..3 SHALL be on consecutive cycles (state BURST), critical word first.
- Word index = (addr[3:2]+k) mod 4, within the aligned block.
- rsp_last=1 on beat 3 only.
REQ-008 Word accesses SHALL ignore addr[1:0]; lane i SHALL map to byte (addr & ~3)+i.
REQ-009 Byte reads SHALL return the addressed byte in lane 0, with lanes 1..3 = 0.
REQ-010 Byte writes SHALL modify only byte addr, taking the value from req_wdata lane 0.
REQ-011 Writes SHALL commit to storage on the acceptance edge; the response SHALL carry the word containing addr after the write.
REQ-012 Addresses SHALL wrap modulo MEM_BYTES, with upper bits ignored and no error response.
REQ-013 While not IDLE, req_ready SHALL be 0 and new requests SHALL be ignored, not queued.
- A request held valid on the cycle returning to IDLE SHALL be accepted on the next edge (earliest: cycle after the last beat).
REQ-014 rsp_data SHALL be held at the last beat value between responses; it is don't-care for checking when rsp_valid=0.
REQ-015 The write path and response path SHALL never read and write the same byte in one cycle.
- A write readback SHALL reflect the new data.

Reset
REQ-016 rst_b low SHALL asynchronously force the following, aborting any in-flight response with no further beats:
- state=IDLE, counter=0
- rsp_valid=0, rsp_last=0, rsp_data=0
- busy=0
REQ-017 Storage contents SHALL NOT be cleared by reset.
- A write accepted before reset remains committed.
REQ-018 req_ready SHALL be 1 in the first cycle after rst_b deasserts.

Structure
REQ-019 Package mips_mem_pkg SHALL hold the following, shared with the cache:
- state enum mem_state_t {IDLE, WAIT, BURST}
- BLOCK_WORDS=4
- default LATENCY
- byte-lane word typedef (4x8)
REQ-020 Storage SHALL be one sub-module, mem_array.
- Byte-addressed, one synchronous write port with per-byte enable, one word-read port.
- Control FSM and counter stay in main_memory.

Verification
REQ-021 Word write then read: write 0x100 data {11,22,33,44}, then read 0x102.
- Read -> one beat, 4 cycles after acceptance, data {11,22,33,44}, rsp_last=1.
REQ-022 Byte write then word read: byte-write 0xAB to 0x101, then word-read 0x100.
- Read -> {11,AB,33,44}.
- Byte-read 0x101 -> {AB,00,00,00}.
REQ-023 Burst: preload 0x200..0x20F with words W0..W3, then burst read at 0x208.
- Beats on 4 consecutive cycles: W2, W3, W0, W1; rsp_last only on the 4th.
REQ-024 Back-to-back and busy: hold req_valid continuously.
- Second request accepted the cycle after the first response's rsp_last.
- A request pulsed while busy -> no response.
REQ-025 Reset mid-burst: assert rst_b after beat 1.
- rsp_valid drops immediately, busy=0, no further beats.
- Prior writes still readable after reset.
REQ-026 Wrap: with MEM_BYTES=8192, write to 0x2000_0010, then read 0x10 -> same data.
